rs232tx: RTL and testbench
==========================

# rs232tx

Parametrised buffered UART transmitter, successor to the fixed 8N1 serial output block. Accepts words from a CPU-side write strobe into a small FIFO and serialises them LSB-first with configurable data width, parity and stop bits. The bit period comes from a run-time divisor rather than a build-time constant, so firmware can change baud rate without resynthesis. Sits behind the SoC I/O register decoder, driving the board TX pin.

## Interface
- DATA_BITS, 8, data bits per frame; legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame; legal 1 or 2
- FIFO_LOG2, 2, FIFO depth = 2^FIFO_LOG2 entries; legal 1..6
- DIV_WIDTH, 16, width of the divisor input

Ports:
- clock  in  1  single system clock; all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- divisor  in  DIV_WIDTH  bit period in clock cycles; values 0 and 1 treated as 2
- transmit_data  in  DATA_BITS  word to enqueue
- we  in  1  enqueue strobe, one word per cycle high
- busy  out  1  FIFO full; a write now is dropped
- idle  out  1  FIFO empty and no frame in progress
- overflow  out  1  one-cycle pulse, a write was dropped
- fifo_count  out  FIFO_LOG2+1  entries currently queued, excluding the frame in flight
- serial_out  out  1  TX line, idle high (mark)

## Operation
- Reset values: serial_out=1, busy=0, idle=1, overflow=0, fifo_count=0, FSM=IDLE, FIFO empty.
- Reset asserted mid-frame aborts the frame; serial_out returns to 1 asynchronously and queued words are discarded.
- FIFO is circular with FIFO_LOG2-bit read/write pointers plus a count. Wrap-around is natural modulo 2^FIFO_LOG2.
- Write: if we=1 and busy=0 at an edge, the word is stored and fifo_count increments.
- Write when busy=1 is dropped and overflow=1 for the next cycle. busy is evaluated before the edge, so a pop on the same edge does not rescue the write.
- Simultaneous write and pop with busy=0: fifo_count is unchanged and both take effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO is non-empty, pop into the shift register, latch the clamped divisor into div_q, and go to START.
  - START: serial_out=0.
  - DATA: DATA_BITS bits, LSB first.
  - PARITY: only when PARITY != 0. Odd: the total number of ones in data plus parity is odd. Even: that total is even.
  - STOP: serial_out=1 for STOP_BITS periods.
  - At the end of STOP, go to START directly if the FIFO is non-empty, else go to IDLE.
- Bit timer is a down-counter loaded with div_q-1 on each bit entry. The bit advances when it reaches 0, so every bit lasts exactly div_q cycles.
- divisor changes take effect only at the next frame start; the frame in flight keeps div_q.

## Timing
- Latency: word written at edge N while idle. Pop and START occur at edge N+1, so serial_out is low from N+1.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × div_q cycles.
- Back-to-back frames: the next start bit begins on the edge ending the last stop period. There is no extra idle cycle.
- idle goes to 1 on the edge ending the final stop bit when the FIFO is empty. It goes to 0 on the edge a write is accepted.
- busy, idle, fifo_count and overflow are registered or derived only from registered state. There is no combinational path from we.

## Test plan
- 8N1, divisor=4: write 0xA5 at edge 0. serial_out from edge 1 = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles. idle=1 at edge 41.
- PARITY=2, divisor=3: write 0x03 → parity bit 0. With PARITY=1, write 0x07 → parity bit 0. With PARITY=1, write 0x00 → parity bit 1.
- FIFO fill, depth 4, divisor=10: writes on edges 0..5.
  - w0 pops at edge 1.
  - fifo_count reaches 4 with busy=1 at edge 4.
  - w5 is dropped and overflow pulses one cycle.
  - Words w0..w4 are transmitted in order.
- STOP_BITS=2, divisor=5, two writes: second start bit follows exactly 10 high cycles after the first frame's last data bit.
- divisor changed from 4 to 8 mid-frame: the current frame keeps 4-cycle bits and the next frame uses 8-cycle bits. divisor=0 gives 2-cycle bits.
- reset pulse during the DATA state with 3 words queued: serial_out=1 with no clock edge, fifo_count=0, and idle=1. No further frames are sent.

Source files
------------

// File: rtl/rs232tx.sv
// Buffered UART transmitter: a circular FIFO feeds a frame serialiser whose bit period
// comes from a run-time divisor.
module rs232tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_LOG2 = 2,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [DATA_BITS-1:0] transmit_data,
  input  logic                 we,
  output logic                 busy,
  output logic                 idle,
  output logic                 overflow,
  output logic [FIFO_LOG2:0]   fifo_count,
  output logic                 serial_out
);

  localparam int                   DEPTH     = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0]   FULL      = (FIFO_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE   = FIFO_LOG2'(1);
  localparam logic [3:0]           LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic                 LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN   = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] timer_q, timer_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 serial_q, serial_d;
  logic                 overflow_q, overflow_d;
  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG2:0]   count_q, count_d;
  logic [DATA_BITS-1:0] fifo_mem [DEPTH];

  logic                 full, empty, push, pop, bit_done, frame_end;
  logic [DIV_WIDTH-1:0] div_clamped;
  logic [DATA_BITS-1:0] head;

  assign full        = (count_q == FULL);
  assign empty       = (count_q == '0);
  assign push        = we & ~full;
  assign head        = fifo_mem[rd_ptr_q];
  assign div_clamped = (divisor < DIV_MIN) ? DIV_MIN : divisor;
  assign bit_done    = (timer_q == '0);
  assign frame_end   = (state_q == S_STOP) && bit_done && (stop_cnt_q == LAST_STOP);
  // A frame ending with words queued pops straight into the next start bit.
  assign pop         = ~empty && ((state_q == S_IDLE) || frame_end);

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    overflow_d = we & full;
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    timer_d    = timer_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    serial_d   = serial_q;
    if (pop) begin
      state_d    = S_START;
      serial_d   = 1'b0;
      shift_d    = head;
      div_d      = div_clamped;
      timer_d    = div_clamped - DIV_ONE;
      parity_d   = (PARITY == 1) ? ~^head : ^head;
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
    end else if (state_q != S_IDLE) begin
      if (!bit_done) begin
        timer_d = timer_q - DIV_ONE;
      end else begin
        timer_d = div_q - DIV_ONE;
        case (state_q)
          S_START: begin
            state_d   = S_DATA;
            serial_d  = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = '0;
          end
          S_DATA: begin
            if (bit_cnt_q == LAST_DATA) begin
              if (PARITY != 0) begin
                state_d  = S_PARITY;
                serial_d = parity_q;
              end else begin
                state_d    = S_STOP;
                serial_d   = 1'b1;
                stop_cnt_d = 1'b0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              serial_d  = shift_q[0];
              shift_d   = shift_q >> 1;
            end
          end
          S_PARITY: begin
            state_d    = S_STOP;
            serial_d   = 1'b1;
            stop_cnt_d = 1'b0;
          end
          S_STOP: begin
            if (frame_end) state_d = S_IDLE;
            else           stop_cnt_d = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= DIV_MIN;
      timer_q    <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      serial_q   <= 1'b1;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      timer_q    <= timer_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      serial_q   <= serial_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= transmit_data;
  end

  assign busy       = full;
  assign idle       = empty && (state_q == S_IDLE);
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign serial_out = serial_q;

endmodule

// File: tb/tb_rs232tx.sv
// Self-checking bench for rs232tx: three configurations checked every cycle against a
// model that expands each accepted word into the per-cycle line levels of its frame.
module tb_rs232tx;

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic [15:0] divisor = 16'd4;

  logic       we_a = 1'b0, we_b = 1'b0, we_c = 1'b0;
  logic [7:0] data_a = '0;
  logic [6:0] data_b = '0;
  logic [7:0] data_c = '0;

  logic       busy_a, idle_a, ovf_a, serial_a;
  logic       busy_b, idle_b, ovf_b, serial_b;
  logic       busy_c, idle_c, ovf_c, serial_c;
  logic [2:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int total = 0;
  int bad   = 0;

  // Per-instance configuration: A = 8N1 depth 4, B = 7O2 depth 4, C = 8E1 depth 2.
  int dbits[3] = '{8, 7, 8};
  int par[3]   = '{0, 1, 2};
  int stops[3] = '{1, 2, 1};
  int depth[3] = '{4, 4, 2};

  int wq[3][$];
  bit lv[3][$];
  bit ovf_exp[3];

  always #5 clock = ~clock;

  rs232tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_LOG2(2), .DIV_WIDTH(16)) dut_a (
    .clock(clock), .reset(reset), .divisor(divisor), .transmit_data(data_a), .we(we_a),
    .busy(busy_a), .idle(idle_a), .overflow(ovf_a), .fifo_count(cnt_a), .serial_out(serial_a)
  );

  rs232tx #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_LOG2(2), .DIV_WIDTH(16)) dut_b (
    .clock(clock), .reset(reset), .divisor(divisor), .transmit_data(data_b), .we(we_b),
    .busy(busy_b), .idle(idle_b), .overflow(ovf_b), .fifo_count(cnt_b), .serial_out(serial_b)
  );

  rs232tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_LOG2(1), .DIV_WIDTH(16)) dut_c (
    .clock(clock), .reset(reset), .divisor(divisor), .transmit_data(data_c), .we(we_c),
    .busy(busy_c), .idle(idle_c), .overflow(ovf_c), .fifo_count(cnt_c), .serial_out(serial_c)
  );

  function automatic logic get_we(int i);
    case (i)
      0:       return we_a;
      1:       return we_b;
      default: return we_c;
    endcase
  endfunction

  function automatic int get_data(int i);
    case (i)
      0:       return int'(data_a);
      1:       return int'(data_b);
      default: return int'(data_c);
    endcase
  endfunction

  // sel: 0 serial_out, 1 busy, 2 idle, 3 overflow, 4 fifo_count
  function automatic logic [31:0] get_out(int i, int sel);
    logic [31:0] r;
    r = '0;
    case (i)
      0: case (sel)
           0: r = {31'b0, serial_a};
           1: r = {31'b0, busy_a};
           2: r = {31'b0, idle_a};
           3: r = {31'b0, ovf_a};
           default: r = {29'b0, cnt_a};
         endcase
      1: case (sel)
           0: r = {31'b0, serial_b};
           1: r = {31'b0, busy_b};
           2: r = {31'b0, idle_b};
           3: r = {31'b0, ovf_b};
           default: r = {29'b0, cnt_b};
         endcase
      default: case (sel)
           0: r = {31'b0, serial_c};
           1: r = {31'b0, busy_c};
           2: r = {31'b0, idle_c};
           3: r = {31'b0, ovf_c};
           default: r = {30'b0, cnt_c};
         endcase
    endcase
    return r;
  endfunction

  function automatic bit model_active();
    bit a;
    a = 1'b0;
    for (int i = 0; i < 3; i++) if (wq[i].size() > 0 || lv[i].size() > 0) a = 1'b1;
    return a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      wq[i].delete();
      lv[i].delete();
      ovf_exp[i] = 1'b0;
    end
  endtask

  // One clock edge of the reference: finish the current line cycle, start the next frame
  // when the line has nothing left to send, then accept or drop the write.
  task automatic model_step(int i);
    bit full, p;
    int w, d, ones;
    full = (wq[i].size() == depth[i]);
    if (lv[i].size() > 0) void'(lv[i].pop_front());
    if (lv[i].size() == 0 && wq[i].size() > 0) begin
      w    = wq[i].pop_front();
      d    = (divisor < 16'd2) ? 2 : int'(divisor);
      ones = 0;
      repeat (d) lv[i].push_back(1'b0);
      for (int b = 0; b < dbits[i]; b++) begin
        ones += (w >> b) & 1;
        repeat (d) lv[i].push_back(((w >> b) & 1) == 1);
      end
      if (par[i] != 0) begin
        p = (par[i] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
        repeat (d) lv[i].push_back(p);
      end
      repeat (stops[i] * d) lv[i].push_back(1'b1);
    end
    if (get_we(i) && !full) wq[i].push_back(get_data(i));
    ovf_exp[i] = get_we(i) && full;
  endtask

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 3; i++) begin
      chk("serial_out", i, get_out(i, 0), (lv[i].size() > 0) ? 32'(lv[i][0]) : 32'd1);
      chk("busy", i, get_out(i, 1), 32'(wq[i].size() == depth[i]));
      chk("idle", i, get_out(i, 2), 32'(wq[i].size() == 0 && lv[i].size() == 0));
      chk("overflow", i, get_out(i, 3), 32'(ovf_exp[i]));
      chk("fifo_count", i, get_out(i, 4), 32'(wq[i].size()));
    end
  endtask

  task automatic applyStimulus(int i, bit w, int d);
    case (i)
      0: begin we_a = w; data_a = 8'(d); end
      1: begin we_b = w; data_b = 7'(d); end
      default: begin we_c = w; data_c = 8'(d); end
    endcase
  endtask

  task automatic clearStimulus();
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 0);
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clock);
    checkOutput();
  endtask

  task automatic run_until_idle(int maxc);
    int n;
    n = 0;
    while (n < maxc && model_active()) begin
      tick();
      n++;
    end
    for (int i = 0; i < 3; i++) chk("drain_idle", i, get_out(i, 2), 32'd1);
  endtask

  initial begin
    model_reset();
    $display("[TB] reset values");
    tick();
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] 8N1 0xA5 at divisor 4");
    divisor = 16'd4;
    applyStimulus(0, 1'b1, 'hA5);
    tick();
    clearStimulus();
    run_until_idle(100);

    $display("[TB] parity frames at divisor 3");
    divisor = 16'd3;
    applyStimulus(2, 1'b1, 'h03);
    applyStimulus(1, 1'b1, 'h07);
    tick();
    clearStimulus();
    applyStimulus(1, 1'b1, 'h00);
    tick();
    clearStimulus();
    run_until_idle(200);

    $display("[TB] FIFO fill and overflow at divisor 10");
    divisor = 16'd10;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1'b1, int'($urandom));
      applyStimulus(2, 1'b1, int'($urandom));
      tick();
    end
    clearStimulus();
    run_until_idle(800);

    $display("[TB] two stop bits at divisor 5");
    divisor = 16'd5;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 1'b1, int'($urandom));
      tick();
    end
    clearStimulus();
    run_until_idle(300);

    $display("[TB] divisor change mid-frame, then divisor 0");
    divisor = 16'd4;
    applyStimulus(0, 1'b1, 'h3C);
    tick();
    applyStimulus(0, 1'b1, 'h5A);
    tick();
    clearStimulus();
    repeat (15) tick();
    divisor = 16'd8;
    run_until_idle(400);
    divisor = 16'd0;
    applyStimulus(0, 1'b1, 'h96);
    tick();
    clearStimulus();
    run_until_idle(100);

    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) applyStimulus(i, $urandom_range(0, 5) == 0, int'($urandom));
      if ($urandom_range(0, 99) == 0) divisor = 16'($urandom_range(0, 5));
      tick();
    end
    clearStimulus();
    run_until_idle(2000);

    $display("[TB] reset during data bits with three words queued");
    divisor = 16'd6;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1'b1, 0);
      tick();
    end
    clearStimulus();
    repeat (6) tick();
    #2 reset = 1'b1;
    #1;
    chk("rst_serial", 0, get_out(0, 0), 32'd1);
    chk("rst_count", 0, get_out(0, 4), 32'd0);
    chk("rst_idle", 0, get_out(0, 2), 32'd1);
    chk("rst_busy", 0, get_out(0, 1), 32'd0);
    tick();
    reset = 1'b0;
    repeat (60) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
